stage3_batch_sched: RTL

- Sequences the stage-3 interval-check datapath over an index range [0, N) in batches of PAR lanes.
- Per batch: issues lane indices, masks the tail, and collects the returned out-of-mode-interval flags in order.
- Maintains per-lane saturating hit counters, a total hit count and the first hit index.
- Sits between the top-level control FSM and the stage-3 lanes; drives idx/lane-enable and consumes the out-of-interval vector.

---
 rtl/stage3_sched_pkg.sv | 49 ++++
 rtl/stage3_lane_cnt.sv | 38 +++
 rtl/stage3_batch_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/stage3_sched_pkg.sv
// ----------------------------------------------------------------------------
// stage3_sched_pkg
// Shared types, default sizes and helper functions for the stage-3 batch
// scheduler.
//   sched_state_e : scheduler FSM states
//   DEF_*         : default lane count, index and counter widths, in-flight limit
//   lane_mask()   : lanes whose index base+l lies inside [0, n)
//   lowest_set()  : lane number of the lowest set bit of a lane vector
// ----------------------------------------------------------------------------
package stage3_sched_pkg;

    localparam int DEF_PAR     = 12;
    localparam int DEF_IDX_W   = 16;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_MAX_OUT = 4;
    localparam int LANE_W      = $clog2(DEF_PAR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    // The base is one bit wider than the element count, so base+l is compared
    // without wrap-around even on the last, partially filled batch.
    function automatic logic [DEF_PAR-1:0] lane_mask(input logic [DEF_IDX_W:0]   base,
                                                     input logic [DEF_IDX_W-1:0] n);
        logic [DEF_PAR-1:0] m;
        m = '0;
        for (int l = 0; l < DEF_PAR; l++) begin
            m[l] = (base + (DEF_IDX_W+1)'(l)) < {1'b0, n};
        end
        return m;
    endfunction

    // Scans from the top lane down so the lowest set lane is the last written.
    function automatic logic [LANE_W-1:0] lowest_set(input logic [DEF_PAR-1:0] vec);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int l = DEF_PAR - 1; l >= 0; l--) begin
            if (vec[l]) begin
                idx = LANE_W'(l);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stage3_lane_cnt.sv
// ----------------------------------------------------------------------------
// stage3_lane_cnt
// Saturating hit counter for one stage-3 lane.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear (takes priority over i_inc)
//   i_inc   : add one, holding at all-ones once reached
//   o_cnt   : current count
// ----------------------------------------------------------------------------
module stage3_lane_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/stage3_batch_sched.sv
// ----------------------------------------------------------------------------
// stage3_batch_sched
// Walks the index range [0, N) in batches of PAR lanes for the stage-3
// interval-check datapath, keeps up to MAX_OUT batches in flight, and folds
// the in-order returned out-of-mode-interval flags into per-lane hit
// counters, a total hit count and the first hit index.
//
// Ports:
//   CLK_i, RST_ni     : clock (rising edge), asynchronous active-low reset
//   start_i, n_elem_i : start pulse (IDLE only) and element count N
//   busy_o, done_o    : run in progress / one-cycle completion pulse
//   issue_valid_o/issue_ready_i : batch handshake towards the lanes
//   idx_o, lane_en_o  : per-lane index base+l and tail mask
//   ret_valid_i, oom_i: returned per-lane out-of-interval flags
//   interval_cnt_o    : per-lane saturating hit counters
//   hit_total_o       : hits over all valid lanes
//   first_hit_vld_o/first_hit_idx_o : smallest index that hit
//   err_o             : sticky, a return arrived with nothing in flight
// ----------------------------------------------------------------------------
module stage3_batch_sched
    import stage3_sched_pkg::*;
#(
    parameter int PAR     = DEF_PAR,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                   CLK_i,
    input  logic                   RST_ni,
    input  logic                   start_i,
    input  logic [IDX_W-1:0]       n_elem_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    output logic [PAR*IDX_W-1:0]   idx_o,
    output logic [PAR-1:0]         lane_en_o,
    input  logic                   ret_valid_i,
    input  logic [PAR-1:0]         oom_i,
    output logic [PAR*CNT_W-1:0]   interval_cnt_o,
    output logic [IDX_W:0]         hit_total_o,
    output logic                   first_hit_vld_o,
    output logic [IDX_W-1:0]       first_hit_idx_o,
    output logic                   err_o
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    sched_state_e       r_state;
    sched_state_e       w_next_state;

    logic [IDX_W-1:0]   r_n;
    logic [IDX_W:0]     r_base;
    logic [IDX_W:0]     r_ret_base;
    logic [OUT_W-1:0]   r_outst;
    logic [IDX_W:0]     r_hit_total;
    logic               r_first_vld;
    logic [IDX_W-1:0]   r_first_idx;
    logic               r_err;

    logic               w_start_acc;
    logic               w_in_issue;
    logic               w_issue_valid;
    logic               w_issue_fire;
    logic               w_last_batch;
    logic               w_ret_fire;
    logic               w_ret_err;
    logic [PAR-1:0]     w_hits;
    logic [IDX_W:0]     w_pop;
    logic [OUT_W-1:0]   w_outst_next;

    assign w_start_acc   = start_i && (r_state == IDLE);
    assign w_in_issue    = (r_state == ISSUE);
    assign w_issue_valid = w_in_issue && (r_outst < OUT_W'(MAX_OUT));
    assign w_issue_fire  = w_issue_valid && issue_ready_i;
    assign w_last_batch  = (r_base + (IDX_W+1)'(PAR)) >= {1'b0, r_n};

    // Returns only count against batches actually in flight; a stray return
    // is dropped and flagged instead.
    assign w_ret_fire = ret_valid_i && (r_outst != '0) && (r_state != IDLE);
    assign w_ret_err  = ret_valid_i && (r_outst == '0);
    assign w_hits     = oom_i & lane_mask(r_ret_base, r_n);

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < PAR; l++) begin
            w_pop = w_pop + {{IDX_W{1'b0}}, w_hits[l]};
        end
    end

    // An issue and a return in the same cycle cancel out.
    always_comb begin
        w_outst_next = r_outst;
        case ({w_issue_fire, w_ret_fire})
            2'b10:   w_outst_next = r_outst + 1'b1;
            2'b01:   w_outst_next = r_outst - 1'b1;
            default: w_outst_next = r_outst;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    w_next_state = (n_elem_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue_fire && w_last_batch) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the final return lands, not a cycle later.
                if (w_outst_next == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o        = (r_state != IDLE);
        done_o        = (r_state == DONE);
        issue_valid_o = w_issue_valid;
    end

    // ---------------- Batch / return bookkeeping ----------------
    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            r_n         <= '0;
            r_base      <= '0;
            r_ret_base  <= '0;
            r_outst     <= '0;
            r_hit_total <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_err       <= 1'b0;
        end else if (w_start_acc) begin
            r_n         <= n_elem_i;
            r_base      <= '0;
            r_ret_base  <= '0;
            r_outst     <= '0;
            r_hit_total <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_err       <= 1'b0;
        end else begin
            r_outst <= w_outst_next;
            if (w_issue_fire) begin
                r_base <= r_base + (IDX_W+1)'(PAR);
            end
            if (w_ret_fire) begin
                r_hit_total <= r_hit_total + w_pop;
                r_ret_base  <= r_ret_base + (IDX_W+1)'(PAR);
                // Returns arrive in index order, so the first batch with any
                // hit holds the smallest hitting index.
                if (!r_first_vld && (w_hits != '0)) begin
                    r_first_vld <= 1'b1;
                    r_first_idx <= r_ret_base[IDX_W-1:0] + IDX_W'(lowest_set(w_hits));
                end
            end
            if (w_ret_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // ---------------- Per-lane outputs and counters ----------------
    // Index and enable are held at zero outside ISSUE; inside ISSUE they only
    // depend on r_base, which moves solely on an accepted batch, so they stay
    // stable while the datapath stalls.
    assign lane_en_o = w_in_issue ? lane_mask(r_base, r_n) : '0;

    for (genvar g = 0; g < PAR; g++) begin : g_lane
        assign idx_o[g*IDX_W +: IDX_W] = w_in_issue ? (r_base[IDX_W-1:0] + IDX_W'(g)) : '0;

        stage3_lane_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_clk   (CLK_i),
            .i_rst_n (RST_ni),
            .i_clr   (w_start_acc),
            .i_inc   (w_ret_fire && w_hits[g]),
            .o_cnt   (interval_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    assign hit_total_o     = r_hit_total;
    assign first_hit_vld_o = r_first_vld;
    assign first_hit_idx_o = r_first_idx;
    assign err_o           = r_err;

endmodule
